// File: rtl/prbs8_checker.sv
// prbs8_checker
//   Receive-side checker for an x^8+x^6+x^5+x^4+1 PRBS8 stream (period 255).
//   A local reference LFSR self-seeds from received words while hunting.
//   After LOCK_CNT consecutive matching words it declares lock. From then on
//   the reference free-runs, and each mismatching word is counted as an error.
//   LOSS_CNT consecutive mismatches drop the checker back into hunting.
//
// Parameters
//   LOCK_CNT   consecutive matching words needed to lock (>=1)
//   LOSS_CNT   consecutive mismatching words that drop lock (>=1)
//   CNT_W      width of the error / word counters
//
// Ports
//   clk          rising-edge clock
//   rst_         asynchronous active-low reset
//   in_vld       in_data valid this cycle
//   in_data      received word; bit0 = newest bit
//   clr          synchronous clear of counters and sat (lock state kept)
//   locked       1 while in LOCKED
//   err_pulse    one-cycle pulse per mismatching valid word while locked
//   err_cnt      saturating count of mismatching words while locked
//   word_cnt     saturating count of valid words checked while locked
//   sat          sticky: a counter reached all-ones
//   zero_det     one-cycle pulse when a valid 8'h00 word arrives
//   bit_err_cnt  (PRBS8_CHK_BITERR_EN only) saturating count of bit errors
//
// Build option
//   PRBS8_CHK_BITERR_EN  adds bit_err_cnt and the popcount of in_data ^ pred.

module prbs8_checker #(
   parameter int unsigned LOCK_CNT = 8,
   parameter int unsigned LOSS_CNT = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             in_vld,
   input  logic [7:0]       in_data,
   input  logic             clr,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] word_cnt,
   output logic             sat,
   output logic             zero_det
`ifdef PRBS8_CHK_BITERR_EN
   ,
   output logic [CNT_W-1:0] bit_err_cnt
`endif
);

   localparam int unsigned MW = $clog2(LOCK_CNT + 1);
   localparam int unsigned SW = $clog2(LOSS_CNT + 1);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state;
   logic [7:0]       ref_q;
   logic [MW-1:0]    match_cnt;
   logic [SW-1:0]    miss_cnt;

   logic [7:0]       pred;
   logic             mismatch;
   logic             zero;
   logic             count_en;
   logic [CNT_W-1:0] err_nxt;
   logic [CNT_W-1:0] word_nxt;
   logic             sat_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + 1'b1;
   endfunction

   assign pred     = {ref_q[6:0], ref_q[3] ^ ref_q[4] ^ ref_q[5] ^ ref_q[7]};
   assign mismatch = (in_data != pred);
   assign zero     = (in_data == 8'h00);
   assign count_en = in_vld && (state == LOCKED);
   assign locked   = (state == LOCKED);

`ifdef PRBS8_CHK_BITERR_EN
   logic [3:0]       pop;
   logic [CNT_W-1:0] bit_nxt;
   logic [CNT_W:0]   bit_sum;

   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         pop = pop + {3'b000, in_data[i] ^ pred[i]};
      end
   end

   // One extra bit catches overflow so the add can clamp at all-ones.
   assign bit_sum = {1'b0, bit_err_cnt} + (CNT_W+1)'(pop);
`endif

   always_comb begin
      err_nxt  = err_cnt;
      word_nxt = word_cnt;
`ifdef PRBS8_CHK_BITERR_EN
      bit_nxt  = bit_err_cnt;
`endif
      if (count_en) begin
         word_nxt = sat_inc(word_cnt);
         if (mismatch) begin
            err_nxt = sat_inc(err_cnt);
`ifdef PRBS8_CHK_BITERR_EN
            bit_nxt = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
`endif
         end
      end
      sat_nxt = sat | (&err_nxt) | (&word_nxt);
`ifdef PRBS8_CHK_BITERR_EN
      sat_nxt = sat_nxt | (&bit_nxt);
`endif
      // clr takes priority over a same-cycle update.
      if (clr) begin
         err_nxt  = '0;
         word_nxt = '0;
         sat_nxt  = 1'b0;
`ifdef PRBS8_CHK_BITERR_EN
         bit_nxt  = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         err_cnt  <= '0;
         word_cnt <= '0;
         sat      <= 1'b0;
`ifdef PRBS8_CHK_BITERR_EN
         bit_err_cnt <= '0;
`endif
      end else begin
         err_cnt  <= err_nxt;
         word_cnt <= word_nxt;
         sat      <= sat_nxt;
`ifdef PRBS8_CHK_BITERR_EN
         bit_err_cnt <= bit_nxt;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state     <= HUNT;
         ref_q     <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         err_pulse <= 1'b0;
         zero_det  <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         zero_det  <= 1'b0;
         if (in_vld) begin
            zero_det <= zero;
            case (state)
               HUNT: begin
                  if (zero) begin
                     match_cnt <= '0;
                  end else begin
                     // Self-seed from the received word.
                     ref_q <= in_data;
                     if (mismatch) begin
                        match_cnt <= '0;
                     end else if (match_cnt == MW'(LOCK_CNT - 1)) begin
                        state     <= LOCKED;
                        match_cnt <= '0;
                     end else begin
                        match_cnt <= match_cnt + 1'b1;
                     end
                  end
               end
               LOCKED: begin
                  // Free-run, so one corrupted word costs exactly one error.
                  ref_q <= pred;
                  if (mismatch) begin
                     err_pulse <= 1'b1;
                     if (miss_cnt == SW'(LOSS_CNT - 1)) begin
                        state    <= HUNT;
                        miss_cnt <= '0;
                     end else begin
                        miss_cnt <= miss_cnt + 1'b1;
                     end
                  end else begin
                     miss_cnt <= '0;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prbs8_checker.sv
module tb_prbs8_checker;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic        in_vld = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        clr = 1'b0;

   logic        locked, err_pulse, sat, zero_det;
   logic [15:0] err_cnt, word_cnt;
   logic        s_locked, s_err_pulse, s_sat, s_zero_det;
   logic [3:0]  s_err_cnt, s_word_cnt;
`ifdef PRBS8_CHK_BITERR_EN
   logic [15:0] bit_err_cnt;
   logic [3:0]  s_bit_err_cnt;
`endif

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   prbs8_checker u_dut (
      .clk(clk), .rst_(rst_), .in_vld(in_vld), .in_data(in_data), .clr(clr),
      .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
      .word_cnt(word_cnt), .sat(sat), .zero_det(zero_det)
`ifdef PRBS8_CHK_BITERR_EN
      , .bit_err_cnt(bit_err_cnt)
`endif
   );

   prbs8_checker #(.LOCK_CNT(8), .LOSS_CNT(32), .CNT_W(4)) u_sat (
      .clk(clk), .rst_(rst_), .in_vld(in_vld), .in_data(in_data), .clr(clr),
      .locked(s_locked), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt),
      .word_cnt(s_word_cnt), .sat(s_sat), .zero_det(s_zero_det)
`ifdef PRBS8_CHK_BITERR_EN
      , .bit_err_cnt(s_bit_err_cnt)
`endif
   );

   // Reference model of the default-parameter checker.
   typedef struct {
      bit          lk;
      bit [7:0]    r;
      int unsigned mt;
      int unsigned ms;
      bit [15:0]   err;
      bit [15:0]   word;
      bit [15:0]   bite;
      bit          sat;
      bit          ep;
      bit          zd;
   } mdl_t;

   mdl_t m;
   mdl_t sbq[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] nxt(input logic [7:0] x);
      return {x[6:0], x[3] ^ x[4] ^ x[5] ^ x[7]};
   endfunction

   function automatic bit [15:0] inc16(input bit [15:0] x, input int unsigned add);
      int unsigned s;
      s = int'(x) + add;
      return (s > 16'hFFFF) ? 16'hFFFF : s[15:0];
   endfunction

   function automatic mdl_t mstep(input mdl_t a, input bit v, input bit [7:0] d, input bit c);
      mdl_t    n;
      bit [7:0] p;
      n    = a;
      p    = nxt(a.r);
      n.ep = 1'b0;
      n.zd = 1'b0;
      if (v) begin
         n.zd = (d == 8'h00);
         if (!a.lk) begin
            if (d == 8'h00) n.mt = 0;
            else begin
               n.r = d;
               if (d != p) n.mt = 0;
               else if (a.mt + 1 == 8) begin n.lk = 1'b1; n.mt = 0; end
               else n.mt = a.mt + 1;
            end
         end else begin
            n.r    = p;
            n.word = inc16(a.word, 1);
            if (d != p) begin
               n.ep   = 1'b1;
               n.err  = inc16(a.err, 1);
               n.bite = inc16(a.bite, $countones(d ^ p));
               if (a.ms + 1 == 4) begin n.lk = 1'b0; n.ms = 0; end
               else n.ms = a.ms + 1;
            end else n.ms = 0;
         end
      end
      if (n.err == 16'hFFFF || n.word == 16'hFFFF) n.sat = 1'b1;
`ifdef PRBS8_CHK_BITERR_EN
      if (n.bite == 16'hFFFF) n.sat = 1'b1;
`endif
      if (c) begin
         n.err = '0; n.word = '0; n.bite = '0; n.sat = 1'b0;
      end
      return n;
   endfunction

   task automatic drive(input logic v, input logic [7:0] d, input logic c);
      mdl_t e;
      @(negedge clk);
      in_vld  = v;
      in_data = d;
      clr     = c;
      m = mstep(m, v, d, c);
      sbq.push_back(m);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sbq.pop_front();
         chk("locked",    locked,    e.lk);
         chk("err_pulse", err_pulse, e.ep);
         chk("err_cnt",   err_cnt,   e.err);
         chk("word_cnt",  word_cnt,  e.word);
         chk("sat",       sat,       e.sat);
         chk("zero_det",  zero_det,  e.zd);
`ifdef PRBS8_CHK_BITERR_EN
         chk("bit_err_cnt", bit_err_cnt, e.bite);
`endif
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_vld = 1'b0;
      clr    = 1'b0;
      rst_   = 1'b0;
      #1;
      chk("rst_locked",   locked,    0);
      chk("rst_err_pls",  err_pulse, 0);
      chk("rst_err_cnt",  err_cnt,   0);
      chk("rst_word_cnt", word_cnt,  0);
      chk("rst_sat",      sat,       0);
      chk("rst_zero_det", zero_det,  0);
      chk("rst_s_locked", s_locked,  0);
      chk("rst_s_err",    s_err_cnt, 0);
`ifdef PRBS8_CHK_BITERR_EN
      chk("rst_bit_err",  bit_err_cnt, 0);
`endif
      m = '{default: 0};
      sbq.delete();
      @(negedge clk);
      rst_ = 1'b1;
   endtask

   logic [7:0] g;

   initial begin
      m = '{default: 0};
      do_reset();

      // 1: lock on a clean stream seeded 8'h01
      g = 8'h01;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, g, 1'b0);
         g = nxt(g);
         if (i == 7) chk("t1_nolock_8th", locked, 0);
         if (i == 8) chk("t1_lock_9th", locked, 1);
      end
      chk("t1_word_cnt", word_cnt, 11);
      chk("t1_err_cnt", err_cnt, 0);

      // 2: single bit-flip while locked
      drive(1'b1, g ^ 8'h01, 1'b0);
      g = nxt(g);
      chk("t2_pulse", err_pulse, 1);
      chk("t2_err_cnt", err_cnt, 1);
      chk("t2_locked", locked, 1);
      drive(1'b1, g, 1'b0);
      g = nxt(g);
      chk("t2_next_ok", err_pulse, 0);
      chk("t2_err_hold", err_cnt, 1);

      // 3: four garbage words drop lock, resumed stream relocks after 8 matches
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, g ^ 8'($urandom_range(1, 255)), 1'b0);
         g = nxt(g);
         if (i == 2) chk("t3_still_lk", locked, 1);
      end
      chk("t3_lost", locked, 0);
      chk("t3_err_cnt", err_cnt, 5);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, g, 1'b0);
         g = nxt(g);
         if (i == 6) chk("t3_nolock_7", locked, 0);
      end
      chk("t3_relock", locked, 1);

      // 4: zero word in HUNT, then gapped stream
      do_reset();
      drive(1'b1, 8'h00, 1'b0);
      chk("t4_zero_det", zero_det, 1);
      chk("t4_zero_nolk", locked, 0);
      g = 8'h01;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, g, 1'b0);
         drive(1'b0, 8'($urandom), 1'b0);
         g = nxt(g);
         if (i == 7) chk("t4_nolock_8", locked, 0);
      end
      chk("t4_lock_gap", locked, 1);
      chk("t4_word_cnt", word_cnt, 0);

      // 5: saturation on the CNT_W=4 / LOSS_CNT=32 instance, then clr
      do_reset();
      g = 8'h5A;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, g, 1'b0);
         g = nxt(g);
      end
      chk("t5_s_locked", s_locked, 1);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, g ^ 8'h01, 1'b0);
         g = nxt(g);
      end
      chk("t5_s_err_sat", s_err_cnt, 4'hF);
      chk("t5_s_sat", s_sat, 1);
      chk("t5_s_still_lk", s_locked, 1);
      drive(1'b0, 8'h00, 1'b1);
      chk("t5_clr_err", s_err_cnt, 0);
      chk("t5_clr_word", s_word_cnt, 0);
      chk("t5_clr_sat", s_sat, 0);
      chk("t5_clr_lk", s_locked, 1);

      // 6: reset mid-LOCKED, then bit-error accounting
      do_reset();
      g = 8'h01;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, g, 1'b0);
         g = nxt(g);
      end
      drive(1'b1, g ^ 8'h80, 1'b0);
      g = nxt(g);
      chk("t6_pre_lk", locked, 1);
      do_reset();
`ifdef PRBS8_CHK_BITERR_EN
      g = 8'h33;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, g, 1'b0);
         g = nxt(g);
      end
      drive(1'b1, g ^ 8'h0F, 1'b0);
      g = nxt(g);
      chk("t6_bit_err", bit_err_cnt, 4);
`endif
      drive(1'b0, 8'h00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
